// File: rtl/arbiter8_pri_rr.sv
// -----------------------------------------------------------------------------
// arbiter8_pri_rr
//   Grants one shared resource to one of eight requesters. The winner is picked
//   either by fixed priority (index 7 highest) or round-robin starting at a
//   rotating pointer. A grant is locked until the holder drops its request. It
//   is also pre-empted after MAX_HOLD cycles if others are waiting and new
//   grants are enabled.
//
// Ports
//   iClk    in   rising-edge clock
//   iRst_n  in   asynchronous reset, active-low
//   iEI     in   enable, active-low (1 = issue no new grants)
//   iMode   in   0 = fixed priority, 1 = round-robin
//   iReq    in   [7:0] level requests, active-high
//   oGnt    out  [7:0] one-hot grant, registered, zero when idle
//   oGntId  out  [2:0] binary index of the granted requester (valid with oValid)
//   oValid  out  a grant is active
//   oEO     out  active-low: 0 when enabled, nothing requested and nothing held
// -----------------------------------------------------------------------------
module arbiter8_pri_rr #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 4
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic       iEI,
  input  logic       iMode,
  input  logic [7:0] iReq,
  output logic [7:0] oGnt,
  output logic [2:0] oGntId,
  output logic       oValid,
  output logic       oEO
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state;
  state_t           stateNext;
  logic [2:0]       ptr;
  logic [2:0]       ptrNext;
  logic [CNT_W-1:0] holdCnt;
  logic [CNT_W-1:0] holdNext;
  logic [7:0]       gntNext;
  logic [2:0]       gntIdNext;
  logic             validNext;
  logic [3:0]       winAll;
  logic [3:0]       winOther;
  logic [7:0]       reqOther;

  // Returns {found, index}. Fixed mode keeps the highest set bit; round-robin
  // walks ptr, ptr+1, ... with 3-bit wrap and keeps the first hit.
  function automatic logic [3:0] pickWinner(
    input logic [7:0] req,
    input logic       mode,
    input logic [2:0] start
  );
    logic       found;
    logic [2:0] idx;
    logic [2:0] j;
    found = 1'b0;
    idx   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (mode == 1'b0) begin
        idx   = req[i] ? 3'(i) : idx;
        found = found | req[i];
      end else begin
        j     = start + 3'(i);
        idx   = (!found && req[j]) ? j : idx;
        found = found | req[j];
      end
    end
    return {found, idx};
  endfunction

  // Candidate winners: one over all requests, one with the current holder masked.
  always_comb begin
    reqOther = iReq & ~oGnt;
    winAll   = pickWinner(iReq, iMode, ptr);
    winOther = pickWinner(reqOther, iMode, ptr);
  end

  // Next-state and next-grant decision.
  always_comb begin
    stateNext = state;
    ptrNext   = ptr;
    holdNext  = holdCnt;
    gntNext   = oGnt;
    gntIdNext = oGntId;
    validNext = oValid;
    case (state)
      IDLE: begin
        if (!iEI && winAll[3]) begin
          stateNext = GRANT;
          gntNext   = 8'd1 << winAll[2:0];
          gntIdNext = winAll[2:0];
          validNext = 1'b1;
          ptrNext   = winAll[2:0] + 3'd1;
          holdNext  = '0;
        end else begin
          stateNext = IDLE;
        end
      end
      GRANT: begin
        if (!iReq[oGntId]) begin
          // Holder released: hand over directly if someone else is waiting.
          if (!iEI && winOther[3]) begin
            gntNext   = 8'd1 << winOther[2:0];
            gntIdNext = winOther[2:0];
            ptrNext   = winOther[2:0] + 3'd1;
            holdNext  = '0;
          end else begin
            stateNext = IDLE;
            gntNext   = 8'd0;
            gntIdNext = 3'd0;
            validNext = 1'b0;
            holdNext  = '0;
          end
        end else if (holdCnt == HOLD_LAST && winOther[3] && !iEI) begin
          // Hold limit reached with others waiting: pre-empt.
          gntNext   = 8'd1 << winOther[2:0];
          gntIdNext = winOther[2:0];
          ptrNext   = winOther[2:0] + 3'd1;
          holdNext  = '0;
        end else begin
          // Keep the holder; counter saturates so a disabled arbiter never times out.
          holdNext = (holdCnt == HOLD_LAST) ? holdCnt : holdCnt + CNT_W'(1);
        end
      end
      default: begin
        stateNext = IDLE;
        gntNext   = 8'd0;
        gntIdNext = 3'd0;
        validNext = 1'b0;
        holdNext  = '0;
        ptrNext   = 3'd0;
      end
    endcase
  end

  // State, pointer, hold counter and registered grant outputs.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state   <= IDLE;
      ptr     <= 3'd0;
      holdCnt <= '0;
      oGnt    <= 8'd0;
      oGntId  <= 3'd0;
      oValid  <= 1'b0;
    end else begin
      state   <= stateNext;
      ptr     <= ptrNext;
      holdCnt <= holdNext;
      oGnt    <= gntNext;
      oGntId  <= gntIdNext;
      oValid  <= validNext;
    end
  end

  // Cascade output: low only when enabled, idle and nothing is requested.
  always_comb begin
    oEO = iEI | (|iReq) | oValid;
  end

endmodule

// File: tb/tb_arbiter8_pri_rr.sv
module tb_arbiter8_pri_rr;

  logic       iClk;
  logic       iRst_n;
  logic       iEI;
  logic       iMode;
  logic [7:0] iReq;
  logic [7:0] oGnt;
  logic [2:0] oGntId;
  logic       oValid;
  logic       oEO;

  typedef struct {
    logic [7:0] gnt;
    logic [2:0] id;
    logic       valid;
    logic       eo;
    logic       chkId;
    string      nm;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  event sampleNow;

  arbiter8_pri_rr #(.MAX_HOLD(16), .CNT_W(4)) dut (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .iEI    (iEI),
    .iMode  (iMode),
    .iReq   (iReq),
    .oGnt   (oGnt),
    .oGntId (oGntId),
    .oValid (oValid),
    .oEO    (oEO)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  function automatic logic [2:0] encode(input logic [7:0] g);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) if (g[i]) r = 3'(i);
    return r;
  endfunction

  task automatic pushExp(input logic [7:0] gnt, input logic eo, input logic chkId,
                         input string nm);
    exp_t e;
    e.gnt   = gnt;
    e.id    = encode(gnt);
    e.valid = |gnt;
    e.eo    = eo;
    e.chkId = chkId;
    e.nm    = nm;
    expQ.push_back(e);
  endtask

  // Apply inputs, let one edge happen, record what must be seen after it.
  task automatic tick(input logic ei, input logic mode, input logic [7:0] req,
                      input logic [7:0] gnt, input logic eo, input string nm);
    iEI   = ei;
    iMode = mode;
    iReq  = req;
    @(posedge iClk);
    pushExp(gnt, eo, |gnt, nm);
    @(negedge iClk);
    #1;
  endtask

  // Monitor: compares DUT outputs against the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge iClk or sampleNow);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checks++;
        if (oGnt !== e.gnt || oValid !== e.valid || oEO !== e.eo ||
            (e.chkId && oGntId !== e.id)) begin
          errors++;
          $display("FAIL %s: got gnt=%h id=%0d valid=%b eo=%b, want gnt=%h id=%0d valid=%b eo=%b",
                   e.nm, oGnt, oGntId, oValid, oEO, e.gnt, e.id, e.valid, e.eo);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    iRst_n = 1'b0;
    iEI    = 1'b1;
    iMode  = 1'b0;
    iReq   = 8'h00;
    // Reset values, including oGntId=0, sampled while reset is held.
    pushExp(8'h00, 1'b1, 1'b1, "reset");
    #12;
    iRst_n = 1'b1;

    // Fixed priority picks 7 out of 0x81.
    tick(1'b0, 1'b0, 8'h81, 8'h80, 1'b1, "t1_fixed_hi");
    // 7 releases, 3 waiting: direct handover.
    tick(1'b0, 1'b0, 8'h08, 8'h08, 1'b1, "t3_grant3");
    // 3 releases, nothing pending: idle, oEO goes low.
    tick(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, "t3_idle");
    tick(1'b0, 1'b0, 8'h20, 8'h20, 1'b1, "t3_grant5");

    // Back-to-back handover 2 -> 4.
    tick(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, "t4_idle");
    tick(1'b0, 1'b0, 8'h04, 8'h04, 1'b1, "t4_grant2");
    tick(1'b0, 1'b0, 8'h14, 8'h04, 1'b1, "t4_hold2");
    tick(1'b0, 1'b0, 8'h10, 8'h10, 1'b1, "t4_nogap");

    // Round-robin from ptr=5 hands 4 -> 5, then disable and exceed the hold limit.
    tick(1'b0, 1'b1, 8'h20, 8'h20, 1'b1, "t5_grant5");
    for (int c = 0; c < 20; c++)
      tick(1'b1, 1'b1, 8'hFF, 8'h20, 1'b1, "t5_persist");
    tick(1'b1, 1'b1, 8'hDF, 8'h00, 1'b1, "t5_release");
    tick(1'b1, 1'b1, 8'hFF, 8'h00, 1'b1, "t5_nogrant_a");
    tick(1'b1, 1'b1, 8'hFF, 8'h00, 1'b1, "t5_nogrant_b");

    // ptr is 6 now: round-robin grants 6, then reset mid-grant.
    tick(1'b0, 1'b1, 8'hFF, 8'h40, 1'b1, "t6_grant6");
    tick(1'b0, 1'b1, 8'hFF, 8'h40, 1'b1, "t6_hold6");
    #1;
    iRst_n = 1'b0;
    pushExp(8'h00, 1'b1, 1'b1, "t6_async_drop");
    #1;
    ->sampleNow;
    @(posedge iClk);
    pushExp(8'h00, 1'b1, 1'b1, "t6_in_reset");
    @(negedge iClk);
    #2;
    iRst_n = 1'b1;

    // Pointer restarted at 0: rotation 0..7,0 with 16 cycles per grant.
    for (int g = 0; g < 9; g++)
      for (int c = 0; c < 16; c++)
        tick(1'b0, 1'b1, 8'hFF, 8'd1 << (g % 8), 1'b1, "t2_rotate");

    // Fixed-priority pre-emption of 0 picks the highest waiter.
    tick(1'b0, 1'b0, 8'hFF, 8'h80, 1'b1, "preempt_fixed");
    tick(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, "final_idle");

    @(negedge iClk);
    @(negedge iClk);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
